// File: rtl/core_pkg.sv
// core_pkg: core-wide widths and the shared types of the fetch/decode
// boundary.
//   FETCH_WIDTH    instructions per fetch bundle
//   XLEN           PC / instruction width
//   fetch_bundle_t one bundle: per-slot valid mask, PCs, instruction words
//   dbq_state_e    decode bundle queue control state
package core_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0]           valid;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] pc;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] instr;
  } fetch_bundle_t;

  typedef enum logic {
    DBQ_RUN        = 1'b0,
    DBQ_FLUSH_HOLD = 1'b1
  } dbq_state_e;

endpackage

// File: rtl/dbq_storage.sv
// dbq_storage: DEPTH-entry bundle register array. It has one write port at
// the tail and one asynchronous read port at the head. It holds no control
// state. The contents have no reset, because the queue's count and pointers
// decide which entries are live.
//   clk    rising-edge clock
//   we     write enable
//   waddr  write index (tail)
//   wdata  bundle to store
//   raddr  read index (head)
//   rdata  bundle at raddr
module dbq_storage
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  fetch_bundle_t wdata,
  input  logic [PW-1:0] raddr,
  output fetch_bundle_t rdata
);

  fetch_bundle_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/decode_bundle_queue.sv
// decode_bundle_queue: bundle FIFO between fetch and decode/rename. It holds
// up to DEPTH bundles and presents the oldest one to decode. On flush it drops
// everything, then holds off fetch for one extra cycle.
//   clk, reset        rising-edge clock, synchronous active-low reset
//   f_valid/pc/instr  incoming fetch bundle (per-slot)
//   fetch_stall_req   queue will not accept a bundle this cycle
//   flush             discard queued and incoming bundles
//   rename_ready      decode consumes the head bundle this cycle
//   d_valid/pc/instr  head bundle. Invalid slots read as 0.
//   q_count           bundles currently held
//   state             control state, exposed for observation
//
// Handshake: fetch offers a bundle by raising any f_valid bit. The bundle is
// taken at the edge only when fetch_stall_req is low in that cycle. A bundle
// with an all-zero mask is never stored. Decode takes the head at the edge
// when d_valid is non-zero and rename_ready is high. fetch_stall_req is built
// from registered state and flush only, so it never depends on rename_ready.
// For that reason a full queue refuses a bundle even when it pops in the same
// cycle.
module decode_bundle_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [FETCH_WIDTH-1:0]           f_valid,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0] f_pc,
  input  logic [FETCH_WIDTH-1:0][XLEN-1:0] f_instr,
  output logic                             fetch_stall_req,
  input  logic                             flush,
  input  logic                             rename_ready,
  output logic [FETCH_WIDTH-1:0]           d_valid,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0] d_pc,
  output logic [FETCH_WIDTH-1:0][XLEN-1:0] d_instr,
  output logic [$clog2(DEPTH):0]           q_count,
  output dbq_state_e                       state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  dbq_state_e    state_q, next_state;
  logic [CW-1:0] count_q;
  logic [PW-1:0] head_q, tail_q;
  logic          run, full, enq, deq;
  fetch_bundle_t wr_bundle, head_bundle;

  assign run  = (state_q == DBQ_RUN) && !flush;
  assign full = (count_q == FULL);
  assign enq  = run && (|f_valid) && !full;
  assign deq  = run && (count_q != '0) && rename_ready;

  assign fetch_stall_req = full || (state_q == DBQ_FLUSH_HOLD) || flush;
  assign q_count         = count_q;
  assign state           = state_q;

  // A flush in any state re-arms the one-cycle hold.
  always_comb begin
    next_state = state_q;
    if (flush) next_state = DBQ_FLUSH_HOLD;
    else if (state_q == DBQ_FLUSH_HOLD) next_state = DBQ_RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= DBQ_RUN;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= next_state;
      if (flush) begin
        count_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        if (enq) tail_q <= tail_q + PW'(1);
        if (deq) head_q <= head_q + PW'(1);
        case ({enq, deq})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign wr_bundle.valid = f_valid;
  assign wr_bundle.pc    = f_pc;
  assign wr_bundle.instr = f_instr;

  dbq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (enq),
    .waddr (tail_q),
    .wdata (wr_bundle),
    .raddr (head_q),
    .rdata (head_bundle)
  );

  // Each slot's PC and instruction pass through only when that slot is valid.
  // Holes and stale storage therefore read as 0.
  always_comb begin
    d_valid = '0;
    d_pc    = '0;
    d_instr = '0;
    if (run && (count_q != '0)) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (head_bundle.valid[i]) begin
          d_valid[i] = 1'b1;
          d_pc[i]    = head_bundle.pc[i];
          d_instr[i] = head_bundle.instr[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_bundle_queue.sv
// tb_decode_bundle_queue: directed vector table for the documented corner
// cases, then randomized traffic. Both are checked against a bundle-queue
// model.
module tb_decode_bundle_queue;
  import core_pkg::*;

  localparam int DEPTH = 4;
  localparam int BW    = $bits(fetch_bundle_t);

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [FETCH_WIDTH-1:0]           f_valid;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] f_pc;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] f_instr;
  logic                             fetch_stall_req;
  logic                             flush;
  logic                             rename_ready;
  logic [FETCH_WIDTH-1:0]           d_valid;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] d_pc;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] d_instr;
  logic [$clog2(DEPTH):0]           q_count;
  dbq_state_e                       state;

  decode_bundle_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .f_valid         (f_valid),
    .f_pc            (f_pc),
    .f_instr         (f_instr),
    .fetch_stall_req (fetch_stall_req),
    .flush           (flush),
    .rename_ready    (rename_ready),
    .d_valid         (d_valid),
    .d_pc            (d_pc),
    .d_instr         (d_instr),
    .q_count         (q_count),
    .state           (state)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];  // bundles the queue should hold, oldest first
  bit            m_hold;    // model is in the post-flush hold cycle

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle's inputs after the falling edge. Then compare the settled
  // outputs against the model's view of the same cycle.
  task automatic drive(input logic [1:0] v, input logic [31:0] pc0,
                       input logic rr, input logic fl, input logic rs);
    fetch_bundle_t h;
    logic [FETCH_WIDTH-1:0]           e_dv;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] e_pc, e_in;
    bit run;
    @(negedge clk);
    f_valid = v;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      f_pc[i]    = pc0 + 32'(4 * i);
      f_instr[i] = (pc0 + 32'(4 * i)) ^ 32'hC0DE_0000;
    end
    rename_ready = rr;
    flush        = fl;
    reset        = rs;
    #1;
    run  = !m_hold && !fl;
    e_dv = '0;
    e_pc = '0;
    e_in = '0;
    if (run && exp_q.size() > 0) begin
      h = exp_q[0];
      e_dv = h.valid;
      for (int i = 0; i < FETCH_WIDTH; i++)
        if (h.valid[i]) begin
          e_pc[i] = h.pc[i];
          e_in[i] = h.instr[i];
        end
    end
    chk("d_valid", 64'(d_valid), 64'(e_dv));
    chk("d_pc", 64'(d_pc), 64'(e_pc));
    chk("d_instr", 64'(d_instr), 64'(e_in));
    chk("q_count", 64'(q_count), 64'(exp_q.size()));
    chk("fetch_stall_req", 64'(fetch_stall_req),
        64'((exp_q.size() == DEPTH) || m_hold || fl));
    chk("state", 64'(state), 64'(m_hold ? DBQ_FLUSH_HOLD : DBQ_RUN));
  endtask

  // Take the rising edge and move the model forward with the held inputs.
  task automatic advance();
    fetch_bundle_t b;
    int n;
    bit do_enq, do_deq;
    @(posedge clk);
    if (!reset) begin
      exp_q.delete();
      m_hold = 0;
    end else if (flush) begin
      exp_q.delete();
      m_hold = 1;
    end else if (m_hold) begin
      m_hold = 0;
    end else begin
      n      = exp_q.size();
      do_deq = (n > 0) && rename_ready;
      do_enq = (|f_valid) && (n < DEPTH);
      if (do_deq) void'(exp_q.pop_front());
      if (do_enq) begin
        b.valid = f_valid;
        b.pc    = f_pc;
        b.instr = f_instr;
        exp_q.push_back(b);
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  v;
    logic [31:0] pc0;
    logic        rr, fl, rs;
    logic [1:0]  e_dv;
    logic [31:0] e_pc0;
    logic [2:0]  e_cnt;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] v, logic [31:0] pc0, logic rr, logic fl, logic rs,
                              logic [1:0] dv, logic [31:0] epc, logic [2:0] cnt, logic st);
    vec_t r;
    r.v = v; r.pc0 = pc0; r.rr = rr; r.fl = fl; r.rs = rs;
    r.e_dv = dv; r.e_pc0 = epc; r.e_cnt = cnt; r.e_stall = st;
    return r;
  endfunction

  initial begin
    int pct;
    // single bundle round trip
    vecs.push_back(mk(2'b11, 32'h100, 1, 0, 1, 2'b00, 32'h0,   3'd0, 0));
    vecs.push_back(mk(2'b00, 32'h0,   1, 0, 1, 2'b11, 32'h100, 3'd1, 0));
    vecs.push_back(mk(2'b00, 32'h0,   0, 0, 1, 2'b00, 32'h0,   3'd0, 0));
    // fill with rename stalled; the fifth bundle is refused
    vecs.push_back(mk(2'b11, 32'h200, 0, 0, 1, 2'b00, 32'h0,   3'd0, 0));
    vecs.push_back(mk(2'b11, 32'h210, 0, 0, 1, 2'b11, 32'h200, 3'd1, 0));
    vecs.push_back(mk(2'b11, 32'h220, 0, 0, 1, 2'b11, 32'h200, 3'd2, 0));
    vecs.push_back(mk(2'b11, 32'h230, 0, 0, 1, 2'b11, 32'h200, 3'd3, 0));
    vecs.push_back(mk(2'b11, 32'h240, 0, 0, 1, 2'b11, 32'h200, 3'd4, 1));
    // full + pop + offer: pop only
    vecs.push_back(mk(2'b11, 32'h250, 1, 0, 1, 2'b11, 32'h200, 3'd4, 1));
    // refill across the pointer wrap, then drain in order
    vecs.push_back(mk(2'b11, 32'h260, 0, 0, 1, 2'b11, 32'h210, 3'd3, 0));
    vecs.push_back(mk(2'b00, 32'h0,   1, 0, 1, 2'b11, 32'h210, 3'd4, 1));
    vecs.push_back(mk(2'b00, 32'h0,   1, 0, 1, 2'b11, 32'h220, 3'd3, 0));
    vecs.push_back(mk(2'b00, 32'h0,   1, 0, 1, 2'b11, 32'h230, 3'd2, 0));
    vecs.push_back(mk(2'b00, 32'h0,   1, 0, 1, 2'b11, 32'h260, 3'd1, 0));
    // partial bundle, then an empty bundle that is not stored
    vecs.push_back(mk(2'b10, 32'h300, 0, 0, 1, 2'b00, 32'h0,   3'd0, 0));
    vecs.push_back(mk(2'b00, 32'h0,   0, 0, 1, 2'b10, 32'h0,   3'd1, 0));
    vecs.push_back(mk(2'b00, 32'h0,   1, 0, 1, 2'b10, 32'h0,   3'd1, 0));
    // three queued, flush with an offered bundle, hold, then accept again
    vecs.push_back(mk(2'b11, 32'h400, 0, 0, 1, 2'b00, 32'h0,   3'd0, 0));
    vecs.push_back(mk(2'b11, 32'h410, 0, 0, 1, 2'b11, 32'h400, 3'd1, 0));
    vecs.push_back(mk(2'b11, 32'h420, 0, 0, 1, 2'b11, 32'h400, 3'd2, 0));
    vecs.push_back(mk(2'b11, 32'h430, 1, 1, 1, 2'b00, 32'h0,   3'd3, 1));
    vecs.push_back(mk(2'b11, 32'h440, 1, 0, 1, 2'b00, 32'h0,   3'd0, 1));
    vecs.push_back(mk(2'b11, 32'h450, 0, 0, 1, 2'b00, 32'h0,   3'd0, 0));
    vecs.push_back(mk(2'b00, 32'h0,   0, 0, 1, 2'b11, 32'h450, 3'd1, 0));
    // flush, then flush again during the hold cycle
    vecs.push_back(mk(2'b00, 32'h0,   0, 1, 1, 2'b00, 32'h0,   3'd1, 1));
    vecs.push_back(mk(2'b00, 32'h0,   0, 1, 1, 2'b00, 32'h0,   3'd0, 1));
    vecs.push_back(mk(2'b00, 32'h0,   0, 0, 1, 2'b00, 32'h0,   3'd0, 1));
    // reset while full
    vecs.push_back(mk(2'b11, 32'h500, 0, 0, 1, 2'b00, 32'h0,   3'd0, 0));
    vecs.push_back(mk(2'b11, 32'h510, 0, 0, 1, 2'b11, 32'h500, 3'd1, 0));
    vecs.push_back(mk(2'b11, 32'h520, 0, 0, 1, 2'b11, 32'h500, 3'd2, 0));
    vecs.push_back(mk(2'b11, 32'h530, 0, 0, 1, 2'b11, 32'h500, 3'd3, 0));
    vecs.push_back(mk(2'b11, 32'h540, 1, 0, 0, 2'b11, 32'h500, 3'd4, 1));
    vecs.push_back(mk(2'b00, 32'h0,   0, 0, 1, 2'b00, 32'h0,   3'd0, 0));
    // reset during the hold cycle
    vecs.push_back(mk(2'b00, 32'h0,   0, 1, 1, 2'b00, 32'h0,   3'd0, 1));
    vecs.push_back(mk(2'b00, 32'h0,   0, 0, 0, 2'b00, 32'h0,   3'd0, 1));
    vecs.push_back(mk(2'b00, 32'h0,   0, 0, 1, 2'b00, 32'h0,   3'd0, 0));

    // initial reset
    reset        = 1'b0;
    flush        = 1'b0;
    rename_ready = 1'b0;
    f_valid      = '0;
    f_pc         = '0;
    f_instr      = '0;
    m_hold       = 0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].v, vecs[k].pc0, vecs[k].rr, vecs[k].fl, vecs[k].rs);
      chk($sformatf("vec%0d_d_valid", k), 64'(d_valid), 64'(vecs[k].e_dv));
      chk($sformatf("vec%0d_d_pc0", k), 64'(d_pc[0]), 64'(vecs[k].e_pc0));
      chk($sformatf("vec%0d_q_count", k), 64'(q_count), 64'(vecs[k].e_cnt));
      chk($sformatf("vec%0d_stall", k), 64'(fetch_stall_req), 64'(vecs[k].e_stall));
      advance();
    end

    // randomized traffic; rename_ready density changes per block so the
    // queue visits empty, full and everything in between
    for (int blk = 0; blk < 6; blk++) begin
      pct = $urandom_range(10, 100);
      for (int c = 0; c < 100; c++) begin
        drive(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
              1'($urandom_range(1, 100) <= pct),
              1'($urandom_range(0, 24) == 0),
              1'($urandom_range(0, 59) != 0));
        advance();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_bundle_queue.md
# decode_bundle_queue

Bundle queue and flow controller between fetch and decode. It buffers up to DEPTH fetch bundles (FETCH_WIDTH slots each) and presents the oldest bundle to decode. It converts rename backpressure into a fetch stall that does not depend combinationally on rename_ready, and discards all in-flight bundles on a pipeline flush. Decode consumes the head bundle, and the queue pops it in the same cycle rename_ready is high.

## Interface
- FETCH_WIDTH, core_pkg value (2), instructions per bundle
- XLEN, core_pkg value (32), PC/instruction width
- DEPTH, 4, bundle entries; power of two, at least 2
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- f_valid  in  FETCH_WIDTH  per-slot valid of incoming fetch bundle
- f_pc  in  XLEN x FETCH_WIDTH  per-slot PC
- f_instr  in  XLEN x FETCH_WIDTH  per-slot instruction word
- fetch_stall_req  out  1  high = queue will not accept a bundle this cycle
- flush  in  1  redirect/mispredict; discard all queued and incoming bundles
- rename_ready  in  1  decode/rename consumes the head bundle this cycle
- d_valid  out  FETCH_WIDTH  per-slot valid of head bundle
- d_pc  out  XLEN x FETCH_WIDTH  head bundle PCs
- d_instr  out  XLEN x FETCH_WIDTH  head bundle instructions
- q_count  out  $clog2(DEPTH)+1  bundles currently held

## Operation
- Storage: DEPTH entries of {mask[FETCH_WIDTH], pc[], instr[]}, plus head/tail pointers ($clog2(DEPTH) bits, natural wrap) and a count.
- FSM has two states, RUN and FLUSH_HOLD.
  - RUN -> FLUSH_HOLD on flush.
  - FLUSH_HOLD -> RUN unconditionally after one cycle.
  - A flush asserted during FLUSH_HOLD re-enters FLUSH_HOLD.
- Enqueue happens when all of these hold: state RUN, no flush, |f_valid, and count < DEPTH. A bundle with f_valid == 0 is never stored. The stored mask equals f_valid exactly; holes are preserved and not compacted.
- Dequeue happens when state RUN, no flush, count != 0 and rename_ready. Head advances by one.
- Simultaneous enqueue and dequeue leaves count unchanged. When full, enqueue is refused even if a dequeue occurs in the same cycle, because fetch_stall_req ignores rename_ready.
- fetch_stall_req = (count == DEPTH) || state == FLUSH_HOLD || flush.
- Head outputs:
  - d_valid = head mask when count != 0, state RUN and no flush. Otherwise d_valid is 0.
  - d_pc and d_instr are driven as 0 whenever d_valid == 0.
- Flush, in the cycle it is asserted:
  - Incoming bundle is dropped and d_valid is forced to 0.
  - Next edge: count = 0, head = tail = 0, state = FLUSH_HOLD.
  - Storage contents need not be cleared.
- Reset (reset == 0 at an edge) overrides everything, including mid-flush and a full queue. Result: count 0, pointers 0, state RUN.
- Reset values of outputs: d_valid 0, d_pc/d_instr 0, q_count 0, fetch_stall_req 0.

## Timing
- Enqueue-to-visible latency is 1 cycle. A bundle accepted at edge N appears on d_* after edge N; there is no same-cycle bypass.
- d_* and q_count are decoded from registered state only. Decode may hold d_* stable while rename_ready is low; the head does not change until it is consumed.
- fetch_stall_req depends on registered state plus flush. There is no rename_ready-to-fetch_stall_req path.
- After flush, the first fetch bundle can be accepted 2 cycles after flush assertion: flush cycle, then FLUSH_HOLD, then RUN.
- Throughput is one bundle per cycle sustained when rename_ready is continuously high.

## Structure
- core_pkg holds FETCH_WIDTH and XLEN (already present).
- core_pkg gains:
  - fetch_bundle_t typedef, packed {valid mask, pc[], instr[]}.
  - dbq_state_e enum {DBQ_RUN, DBQ_FLUSH_HOLD}.
- Optional sub-module: dbq_storage, a DEPTH-entry register array with write-at-tail and read-at-head. All control stays in decode_bundle_queue.

## Test plan
- Reset, then one bundle f_valid=2'b11, pc=0x100/0x104, rename_ready=1 -> d_valid=2'b11 with pc 0x100/0x104 one cycle later; q_count returns to 0 the cycle after.
- rename_ready=0, 5 back-to-back bundles -> 4 accepted, fetch_stall_req=1 from the 5th cycle, q_count=4; d_* stays on the first bundle.
- Queue full, rename_ready=1 for one cycle with a bundle offered -> dequeue only, q_count=3, offered bundle not stored; order of the remaining bundles is preserved across pointer wrap.
- Partial bundle f_valid=2'b10 -> d_valid=2'b10; slot 0 pc/instr read 0. A bundle with f_valid=2'b00 -> q_count unchanged.
- 3 bundles queued, flush with a bundle offered -> d_valid=0 that cycle, q_count=0 next cycle, fetch_stall_req=1 for 2 cycles, then a new bundle is accepted and appears one cycle later.
- reset low while full and during FLUSH_HOLD -> all outputs 0 at the next edge, state RUN, fetch_stall_req=0.
